// File: rtl/asset_access_arbiter.sv
// rtl/asset_access_arbiter.sv - protected asset access arbiter with permission mask, grant bound and lockout
//
// Shares one protected asset between N_REQ requesters and closes the asset's control loop.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req[N_REQ]        level requests, one per requester
//   cfg_we, cfg_mask  permission mask write (honoured only in IDLE with no winning request)
//   gnt[N_REQ]        registered one-hot grant
//   access_en         registered asset access enable
//   observe_in        asset observe port, must echo access_en
//   control_in        asset control_port_in
//   control_out       asset control_port_out, passes control_in only while granted
//   viol_pulse        registered one-cycle violation strobe
//   viol_count        saturating violation count
//   locked            high during lockout
//   busy              high during grant or release
module asset_access_arbiter #(
    parameter int               N_REQ       = 4,
    parameter int               HOLD_CYCLES = 8,
    parameter int               MAX_VIOL    = 3,
    parameter int               LOCK_CYCLES = 64,
    parameter logic [N_REQ-1:0] MASK_RST    = 4'b0001
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req,
    input  logic                            cfg_we,
    input  logic [N_REQ-1:0]                cfg_mask,
    output logic [N_REQ-1:0]                gnt,
    output logic                            access_en,
    input  logic                            observe_in,
    input  logic                            control_in,
    output logic                            control_out,
    output logic                            viol_pulse,
    output logic [$clog2(MAX_VIOL+1)-1:0]   viol_count,
    output logic                            locked,
    output logic                            busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int VW = $clog2(MAX_VIOL + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [N_REQ-1:0]  mask, mask_next;
    logic [N_REQ-1:0]  gnt_next;
    logic              access_en_next;
    logic              viol_pulse_next;
    logic [VW-1:0]     viol_count_next;
    logic [PW-1:0]     rr_ptr, rr_ptr_next;
    logic [PW-1:0]     owner, owner_next;
    logic [HW-1:0]     hold_cnt, hold_cnt_next;
    logic [LW-1:0]     lock_cnt, lock_cnt_next;

    logic              win_valid;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     cand;
    logic              tamper;

    // Round-robin pick: scan downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = PW'((int'(rr_ptr) + k) % N_REQ);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // The asset must echo the enable we drive; lockout already has the enable forced low.
    assign tamper = (state != S_LOCKOUT) && (observe_in != access_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            gnt        <= '0;
            access_en  <= 1'b0;
            viol_pulse <= 1'b0;
            viol_count <= '0;
            mask       <= MASK_RST;
            rr_ptr     <= '0;
            owner      <= '0;
            hold_cnt   <= '0;
            lock_cnt   <= '0;
        end else begin
            state      <= state_next;
            gnt        <= gnt_next;
            access_en  <= access_en_next;
            viol_pulse <= viol_pulse_next;
            viol_count <= viol_count_next;
            mask       <= mask_next;
            rr_ptr     <= rr_ptr_next;
            owner      <= owner_next;
            hold_cnt   <= hold_cnt_next;
            lock_cnt   <= lock_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        gnt_next        = gnt;
        access_en_next  = access_en;
        viol_pulse_next = 1'b0;
        viol_count_next = viol_count;
        mask_next       = mask;
        rr_ptr_next     = rr_ptr;
        owner_next      = owner;
        hold_cnt_next   = hold_cnt;
        lock_cnt_next   = lock_cnt;

        if (tamper) begin
            state_next      = S_LOCKOUT;
            gnt_next        = '0;
            access_en_next  = 1'b0;
            viol_pulse_next = 1'b1;
            lock_cnt_next   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        rr_ptr_next = PW'((int'(win_idx) + 1) % N_REQ);
                        if (mask[win_idx]) begin
                            state_next     = S_GRANT;
                            owner_next     = win_idx;
                            gnt_next       = N_REQ'(1) << win_idx;
                            access_en_next = 1'b1;
                            hold_cnt_next  = HW'(HOLD_CYCLES - 1);
                        end else begin
                            viol_pulse_next = 1'b1;
                            if (viol_count < VW'(MAX_VIOL))
                                viol_count_next = viol_count + 1'b1;
                            if (viol_count_next == VW'(MAX_VIOL)) begin
                                state_next    = S_LOCKOUT;
                                lock_cnt_next = '0;
                            end
                        end
                    end else if (cfg_we) begin
                        mask_next = cfg_mask;
                    end
                end
                S_GRANT: begin
                    // Hold expiry and request drop both end the grant the same way.
                    if (!req[owner] || hold_cnt == '0) begin
                        state_next     = S_RELEASE;
                        gnt_next       = '0;
                        access_en_next = 1'b0;
                    end else begin
                        hold_cnt_next = hold_cnt - 1'b1;
                    end
                end
                S_RELEASE: begin
                    state_next = S_IDLE;
                end
                S_LOCKOUT: begin
                    if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
                        state_next      = S_IDLE;
                        viol_count_next = '0;
                        lock_cnt_next   = '0;
                    end else begin
                        lock_cnt_next = lock_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        locked      = (state == S_LOCKOUT);
        busy        = (state == S_GRANT) || (state == S_RELEASE);
        control_out = control_in & (state == S_GRANT) & ~locked;
    end

endmodule

// File: tb/tb_asset_access_arbiter.sv
// tb/tb_asset_access_arbiter.sv - scoreboard testbench for asset_access_arbiter
module tb_asset_access_arbiter;

    localparam int N      = 4;
    localparam int HOLD   = 8;
    localparam int MAXV   = 3;
    localparam int LOCKC  = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       cfg_we;
    logic [3:0] cfg_mask;
    logic [3:0] gnt;
    logic       access_en;
    logic       observe_in;
    logic       control_in;
    logic       control_out;
    logic       viol_pulse;
    logic [1:0] viol_count;
    logic       locked;
    logic       busy;
    logic       tamper_inj;

    int n_checks = 0;
    int n_err    = 0;

    asset_access_arbiter #(
        .N_REQ(N), .HOLD_CYCLES(HOLD), .MAX_VIOL(MAXV), .LOCK_CYCLES(LOCKC), .MASK_RST(4'b0001)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
        .gnt(gnt), .access_en(access_en), .observe_in(observe_in),
        .control_in(control_in), .control_out(control_out),
        .viol_pulse(viol_pulse), .viol_count(viol_count), .locked(locked), .busy(busy)
    );

    always #5 clk = ~clk;

    // A healthy asset echoes the enable; tamper_inj corrupts the echo.
    assign observe_in = access_en ^ tamper_inj;

    typedef struct {
        logic [3:0] gnt;
        logic       ae;
        logic       vp;
        logic [1:0] vc;
        logic       lk;
        logic       bz;
        logic       co;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: the asset is either free, owned (with an age), cooling down,
    // or locked out (with an age).
    localparam int PH_FREE = 0, PH_OWNED = 1, PH_COOL = 2, PH_LOCK = 3;
    int         m_ph;
    int         m_owner;
    int         m_age;
    int         m_lock_age;
    int         m_ptr;
    int         m_viol;
    logic [3:0] m_mask;

    task automatic model_reset();
        m_ph = PH_FREE; m_owner = 0; m_age = 0; m_lock_age = 0;
        m_ptr = 0; m_viol = 0; m_mask = 4'b0001;
    endtask

    task automatic push_exp(input logic vp, input logic ci);
        exp_t e;
        e.gnt = (m_ph == PH_OWNED) ? 4'(1 << m_owner) : 4'b0000;
        e.ae  = (m_ph == PH_OWNED);
        e.vp  = vp;
        e.vc  = 2'(m_viol);
        e.lk  = (m_ph == PH_LOCK);
        e.bz  = (m_ph == PH_OWNED) || (m_ph == PH_COOL);
        e.co  = ci && (m_ph == PH_OWNED);
        sb_q.push_back(e);
    endtask

    task automatic model_step(input logic [3:0] r, input logic we, input logic [3:0] cm,
                              input logic inj, input logic ci);
        logic vp;
        int   w;
        bit   found;
        vp = 1'b0;
        if (inj && m_ph != PH_LOCK) begin
            m_ph = PH_LOCK; m_lock_age = 0; vp = 1'b1;
        end else begin
            case (m_ph)
                PH_FREE: begin
                    found = 0; w = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && r[(m_ptr + k) % N]) begin
                            w = (m_ptr + k) % N; found = 1;
                        end
                    end
                    if (found) begin
                        m_ptr = (w + 1) % N;
                        if (m_mask[w]) begin
                            m_ph = PH_OWNED; m_owner = w; m_age = 0;
                        end else begin
                            vp = 1'b1;
                            if (m_viol < MAXV) m_viol++;
                            if (m_viol == MAXV) begin
                                m_ph = PH_LOCK; m_lock_age = 0;
                            end
                        end
                    end else if (we) begin
                        m_mask = cm;
                    end
                end
                PH_OWNED: begin
                    if (!r[m_owner] || m_age == HOLD - 1) m_ph = PH_COOL;
                    else m_age++;
                end
                PH_COOL: m_ph = PH_FREE;
                default: begin
                    if (m_lock_age == LOCKC - 1) begin
                        m_ph = PH_FREE; m_viol = 0;
                    end else begin
                        m_lock_age++;
                    end
                end
            endcase
        end
        push_exp(vp, ci);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs after every active edge with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("gnt",         32'(gnt),         32'(e.gnt));
                chk("access_en",   32'(access_en),   32'(e.ae));
                chk("viol_pulse",  32'(viol_pulse),  32'(e.vp));
                chk("viol_count",  32'(viol_count),  32'(e.vc));
                chk("locked",      32'(locked),      32'(e.lk));
                chk("busy",        32'(busy),        32'(e.bz));
                chk("control_out", 32'(control_out), 32'(e.co));
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic we, input logic [3:0] cm,
                         input logic inj, input logic ci);
        @(negedge clk);
        rst = 1'b0; req = r; cfg_we = we; cfg_mask = cm; tamper_inj = inj; control_in = ci;
        model_step(r, we, cm, inj, ci);
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst = 1'b1; req = '0; cfg_we = 1'b0; cfg_mask = '0; tamper_inj = 1'b0;
        control_in = 1'($urandom);
        model_reset();
        push_exp(1'b0, 1'b0);
    endtask

    task automatic hold_req(input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) drive(r, 1'b0, 4'b0000, 1'b0, 1'($urandom));
    endtask

    task automatic cfg_write(input logic [3:0] cm);
        hold_req(4'b0000, 3);
        for (int i = 0; i < 2; i++) drive(4'b0000, 1'b1, cm, 1'b0, 1'($urandom));
    endtask

    initial begin
        logic [3:0] r;
        rst = 1'b1; req = '0; cfg_we = 1'b0; cfg_mask = '0; tamper_inj = 1'b0; control_in = 1'b0;
        model_reset();

        for (int i = 0; i < 3; i++) reset_cycle();

        // Single permitted requester holding its request: bounded grant, release, re-grant.
        hold_req(4'b0001, 20);
        hold_req(4'b0000, 4);

        // All requesters permitted: grants rotate.
        cfg_write(4'b1111);
        hold_req(4'b1111, 45);

        // Three separate unpermitted attempts lead to lockout, which then expires.
        cfg_write(4'b0001);
        for (int a = 0; a < 3; a++) begin
            hold_req(4'b0010, 1);
            hold_req(4'b0000, 2);
        end
        hold_req(4'b0000, 70);

        // Tamper during a grant.
        hold_req(4'b0001, 3);
        drive(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1);
        hold_req(4'b0001, 2);
        hold_req(4'b0000, 70);

        // Mask write during a grant is dropped; the same write in IDLE sticks.
        hold_req(4'b0001, 2);
        drive(4'b0001, 1'b1, 4'b0100, 1'b0, 1'b1);
        hold_req(4'b0000, 4);
        hold_req(4'b0100, 1);
        hold_req(4'b0000, 3);
        cfg_write(4'b0100);
        hold_req(4'b0100, 5);
        hold_req(4'b0000, 70);

        // Randomised traffic with occasional mask writes and tamper.
        r = 4'($urandom);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            drive(r, ($urandom_range(0, 9) == 0), 4'($urandom),
                  ($urandom_range(0, 99) == 0), 1'($urandom));
        end

        // Reset in the middle of a grant with a non-zero violation count.
        hold_req(4'b0000, 70);
        cfg_write(4'b0101);
        hold_req(4'b0010, 1);
        hold_req(4'b0000, 2);
        hold_req(4'b0001, 3);
        @(negedge clk);
        control_in = 1'b1;
        rst = 1'b1;
        #1;
        chk("async_gnt",         32'(gnt),         32'd0);
        chk("async_access_en",   32'(access_en),   32'd0);
        chk("async_control_out", 32'(control_out), 32'd0);
        chk("async_viol_count",  32'(viol_count),  32'd0);
        model_reset();
        push_exp(1'b0, 1'b0);
        reset_cycle();
        hold_req(4'b1111, 6);
        hold_req(4'b0110, 3);

        @(posedge clk);
        @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
